fill_engine: RTL
================

# fill_engine

Parametrised successor to the single-mode span fill block. Given a triangle's bounding coordinates, a per-row edge mask from the rasteriser's line buffer, and a fill mode, `fill_engine` performs read-modify-write of each affected frame-buffer row through a req/ack memory port. It sits between the line rasteriser (edge-mask producer) and the SRAM controller, and adds fill modes, a variable row count, empty-row skipping and wait-state tolerant memory access.

## Interface
- `PIXEL_BITS`, 24: bits per pixel (RGB888).
- `ROW_PIXELS`, 64: pixels per memory word and per edge-mask row.
- `NUM_ROWS`, 64: maximum rows per fill; edge buffer depth.
- `COORD_BITS`, 8: bits per x/y coordinate.
- `ADDR_BITS`, 24: memory address width.
- `ROW_STRIDE`, 256: address increment between rows.
- `LAYER_STRIDE`, 65536: address offset of layer 1.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `coordinates` in 6*COORD_BITS: {y2,x2,y1,x1,y0,x0}, x in low byte of each pair.
- `row_count` in $clog2(NUM_ROWS+1): rows to process; 0 means none.
- `fill_mode` in 2: 0 SPAN, 1 PARITY, 2 OUTLINE, 3 reserved (treated as SPAN).
- `color_code` in PIXEL_BITS: fill color.
- `blend` in 1: 50% blend request (see Configuration).
- `layer_num` in 1: target layer.
- `line_buffer` in NUM_ROWS*ROW_PIXELS: edge masks; row r at [r*ROW_PIXELS +: ROW_PIXELS]; held stable while `busy`.
- `busy` out 1: high from the cycle after `start` is accepted until DONE exits.
- `fill_done` out 1: one-cycle pulse in DONE.
- `mem_req`, `mem_we` out 1: request and write strobe; held until `mem_ack`.
- `mem_ack` in 1: request completion; read data valid in the ack cycle.
- `address` out ADDR_BITS: request address, 0 when `mem_req` is low.
- `read_data` in ROW_PIXELS*PIXEL_BITS, `write_data` out ROW_PIXELS*PIXEL_BITS: row data.

## Operation
- States: IDLE, SETUP, RD_REQ, SCAN, FILL, WR_REQ, NEXT, DONE.
- IDLE→SETUP on `start`. SETUP captures mode, color, blend, layer and row_count, and computes xmin and ymin as the minimum of the three x and the three y values. base = layer*LAYER_STRIDE + ymin*ROW_STRIDE + xmin, mod 2^ADDR_BITS. Sets row index r=0. If row_count==0, goes to DONE; otherwise goes to RD_REQ.
- RD_REQ: mem_req=1, mem_we=0, address=base+r*ROW_STRIDE (wraps mod 2^ADDR_BITS). On ack, latch read_data into the row register and go to SCAN.
- SCAN: compute fill mask from edge row r.
  - SPAN: pixels from the lowest to the highest set bit, inclusive.
  - PARITY: a pixel is set if its edge bit is set, or if an odd number of edge bits lie strictly below it.
  - OUTLINE: edge bits only.
  - Empty mask: go to NEXT with no write. Otherwise go to FILL.
- FILL: each masked pixel is replaced with color_code (or the blend result). Unmasked pixels keep their read value. Go to WR_REQ.
- WR_REQ: mem_req=1, mem_we=1, same address, write_data = row register. On ack, go to NEXT.
- NEXT: r=r+1. If r==row_count or r==NUM_ROWS, go to DONE; otherwise go to RD_REQ.
- DONE: fill_done=1, then go to IDLE.
- `start` while busy is ignored. `row_count` > NUM_ROWS is clamped to NUM_ROWS.
- `rst` in any state goes to IDLE and drops mem_req in the same edge. Any pending write is abandoned.
- Reset values: busy=0, fill_done=0, mem_req=0, mem_we=0, address=0, write_data=0.

## Timing
- Zero-wait memory (ack in the first req cycle):
  - Non-empty row: 5 cycles (RD, SCAN, FILL, WR, NEXT).
  - Empty row: 3 cycles.
  - Start-to-done overhead: IDLE accept + SETUP + DONE.
- Each wait state adds one cycle per access. Address and we must be stable while req is high.
- fill_done asserts exactly once per accepted start, including row_count=0, where it occurs 2 cycles after start.

## Configuration
- `FILL_BLEND_EN` defined: when captured blend=1, each masked pixel = per-8-bit-channel (old+new)>>1, truncated.
- `FILL_BLEND_EN` undefined: the `blend` port remains but is ignored. Masked pixels are always overwritten with color_code.

## Structure
- `fill_pkg` holds:
  - the state enum and the fill_mode enum (SPAN/PARITY/OUTLINE);
  - default constants ROW_STRIDE and LAYER_STRIDE;
  - a `blend_px` function.
- Sub-module `span_mask_gen`: purely combinational. Takes (edge row, mode) and produces (fill mask, empty flag). Instantiated once and tested standalone.

## Test plan
- SPAN, coords x={10,4,20} y={30,12,40}, layer 0, row_count=2, row0 edges bits 3 and 9, zero-wait ack → first read at 0x000C04, pixels 3..9 = color, write to 0x000C04; second access at 0x000D04; fill_done after 12 cycles.
- PARITY, edges at bits 2,5,10,12 → pixels 2–5 and 10–12 written; 0–1, 6–9, 13–63 unchanged.
- OUTLINE on layer 1, ymin=xmin=0, edges bits 0 and 63 → only those pixels changed, address 0x010000.
- Empty edge row in the middle of 3 rows → exactly 2 writes; row_count=0 → no mem_req, fill_done pulse 2 cycles after start.
- ack delayed 3 cycles on each access → req, address and we held stable throughout; `rst` asserted during WR_REQ → mem_req=0 next cycle, no fill_done, IDLE.
- `FILL_BLEND_EN` with blend=1: old 0x204060, color 0x406080 → 0x305070; build without the macro → 0x406080.

Source files
------------

// File: rtl/fill_pkg.sv
// ---------------------------------------------------------------------------
// fill_pkg
// Shared types and helpers for the frame-buffer fill engine.
//   fill_state_e : sequencing states of fill_engine
//   fill_mode_e  : fill mode encoding (value 3 is reserved and behaves as SPAN)
//   DEF_ROW_STRIDE / DEF_LAYER_STRIDE : default address geometry
//   blend_px     : per-8-bit-channel 50% blend, truncated
// ---------------------------------------------------------------------------
package fill_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_RD_REQ = 3'd2,
      ST_SCAN   = 3'd3,
      ST_FILL   = 3'd4,
      ST_WR_REQ = 3'd5,
      ST_NEXT   = 3'd6,
      ST_DONE   = 3'd7
   } fill_state_e;

   typedef enum logic [1:0] {
      MODE_SPAN    = 2'd0,
      MODE_PARITY  = 2'd1,
      MODE_OUTLINE = 2'd2,
      MODE_RSVD    = 2'd3
   } fill_mode_e;

   localparam int DEF_ROW_STRIDE   = 256;
   localparam int DEF_LAYER_STRIDE = 65536;

   // Widest pixel the blend helper handles; callers zero-extend narrower
   // pixels into it and truncate the result back.
   localparam int BLEND_MAX_BITS = 64;

   // Average each 8-bit channel of old and new, dropping the carry-out LSB.
   function automatic logic [BLEND_MAX_BITS-1:0] blend_px(
      input logic [BLEND_MAX_BITS-1:0] old_px,
      input logic [BLEND_MAX_BITS-1:0] new_px
   );
      logic [BLEND_MAX_BITS-1:0] res;
      logic [8:0]                sum;
      res = '0;
      for (int c = 0; c < BLEND_MAX_BITS / 8; c++) begin
         sum              = {1'b0, old_px[c*8 +: 8]} + {1'b0, new_px[c*8 +: 8]};
         res[c*8 +: 8]    = sum[8:1];
      end
      return res;
   endfunction

endpackage

// File: rtl/span_mask_gen.sv
// ---------------------------------------------------------------------------
// span_mask_gen
// Purely combinational conversion of one edge-mask row into a fill mask.
// Ports:
//   edge_row  in  ROW_PIXELS : edge bits of the row (bit i = pixel i)
//   mode      in  2          : 0 SPAN, 1 PARITY, 2 OUTLINE, 3 as SPAN
//   fill_mask out ROW_PIXELS : pixels to be filled
//   empty     out 1          : no pixel selected
// ---------------------------------------------------------------------------
module span_mask_gen
   import fill_pkg::*;
#(
   parameter int ROW_PIXELS = 64
) (
   input  logic [ROW_PIXELS-1:0] edge_row,
   input  logic [1:0]            mode,
   output logic [ROW_PIXELS-1:0] fill_mask,
   output logic                  empty
);

   logic [ROW_PIXELS-1:0] from_low;
   logic [ROW_PIXELS-1:0] to_high;
   logic [ROW_PIXELS-1:0] odd_below;
   logic                  run_or_up;
   logic                  run_or_dn;
   logic                  run_xor;

   // Upward sweep: from_low marks pixels at or above the lowest edge bit,
   // odd_below marks pixels with an odd count of edge bits strictly below.
   always_comb begin
      from_low  = '0;
      odd_below = '0;
      run_or_up = 1'b0;
      run_xor   = 1'b0;
      for (int i = 0; i < ROW_PIXELS; i++) begin
         odd_below[i] = run_xor;
         run_xor      = run_xor ^ edge_row[i];
         run_or_up    = run_or_up | edge_row[i];
         from_low[i]  = run_or_up;
      end
   end

   // Downward sweep: to_high marks pixels at or below the highest edge bit.
   always_comb begin
      to_high   = '0;
      run_or_dn = 1'b0;
      for (int i = ROW_PIXELS - 1; i >= 0; i--) begin
         run_or_dn  = run_or_dn | edge_row[i];
         to_high[i] = run_or_dn;
      end
   end

   // Mode select; the reserved encoding falls through to the span fill.
   always_comb begin
      fill_mask = from_low & to_high;
      case (fill_mode_e'(mode))
         MODE_PARITY:  fill_mask = edge_row | odd_below;
         MODE_OUTLINE: fill_mask = edge_row;
         default:      fill_mask = from_low & to_high;
      endcase
   end

   assign empty = ~|fill_mask;

endmodule

// File: rtl/fill_engine.sv
// ---------------------------------------------------------------------------
// fill_engine
// Read-modify-write fill of frame-buffer rows under a per-row edge mask.
// Optional feature macro: FILL_BLEND_EN (50% per-channel blend when the
// captured blend input is 1; without it the blend port is ignored).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle request, accepted only when idle
//   coordinates     : {y2,x2,y1,x1,y0,x0}
//   row_count       : rows to process (0 = none, clamped to NUM_ROWS)
//   fill_mode       : 0 SPAN, 1 PARITY, 2 OUTLINE, 3 as SPAN
//   color_code      : fill colour
//   blend           : blend request
//   layer_num       : target layer
//   line_buffer     : edge masks, row r at [r*ROW_PIXELS +: ROW_PIXELS]
//   busy, fill_done : status and one-cycle completion pulse
//   mem_req/mem_we/mem_ack/address/read_data/write_data : row memory port
// ---------------------------------------------------------------------------
module fill_engine
   import fill_pkg::*;
#(
   parameter int PIXEL_BITS   = 24,
   parameter int ROW_PIXELS   = 64,
   parameter int NUM_ROWS     = 64,
   parameter int COORD_BITS   = 8,
   parameter int ADDR_BITS    = 24,
   parameter int ROW_STRIDE   = DEF_ROW_STRIDE,
   parameter int LAYER_STRIDE = DEF_LAYER_STRIDE
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [6*COORD_BITS-1:0]          coordinates,
   input  logic [$clog2(NUM_ROWS+1)-1:0]    row_count,
   input  logic [1:0]                       fill_mode,
   input  logic [PIXEL_BITS-1:0]            color_code,
   input  logic                             blend,
   input  logic                             layer_num,
   input  logic [NUM_ROWS*ROW_PIXELS-1:0]   line_buffer,
   output logic                             busy,
   output logic                             fill_done,
   output logic                             mem_req,
   output logic                             mem_we,
   input  logic                             mem_ack,
   output logic [ADDR_BITS-1:0]             address,
   input  logic [ROW_PIXELS*PIXEL_BITS-1:0] read_data,
   output logic [ROW_PIXELS*PIXEL_BITS-1:0] write_data
);

   localparam int RC_BITS  = $clog2(NUM_ROWS + 1);
   localparam int ROW_BITS = ROW_PIXELS * PIXEL_BITS;
   localparam logic [RC_BITS-1:0] MAX_ROWS = RC_BITS'(NUM_ROWS);

   fill_state_e             state_q, state_d;
   logic [RC_BITS-1:0]      r_q, r_d;
   logic [RC_BITS-1:0]      rc_q, rc_d;
   logic [1:0]              mode_q, mode_d;
   logic [PIXEL_BITS-1:0]   color_q, color_d;
   logic [ADDR_BITS-1:0]    addr_q, addr_d;
   logic [ROW_BITS-1:0]     row_q, row_d;
   logic [ROW_PIXELS-1:0]   mask_q, mask_d;

   logic [COORD_BITS-1:0]   xmin;
   logic [COORD_BITS-1:0]   ymin;
   logic [ADDR_BITS-1:0]    base_addr;
   logic [ROW_PIXELS-1:0]   edge_row;
   logic [ROW_PIXELS-1:0]   scan_mask;
   logic                    scan_empty;
   logic [ROW_BITS-1:0]     filled_row;

`ifdef FILL_BLEND_EN
   logic                    blend_q, blend_d;
`else
   logic                    unused_blend;
   assign unused_blend = blend;
`endif

   // Bounding-box corner: minimum x and minimum y over the three vertices.
   always_comb begin
      xmin = coordinates[0 +: COORD_BITS];
      ymin = coordinates[COORD_BITS +: COORD_BITS];
      for (int v = 1; v < 3; v++) begin
         if (coordinates[2*v*COORD_BITS +: COORD_BITS] < xmin)
            xmin = coordinates[2*v*COORD_BITS +: COORD_BITS];
         if (coordinates[(2*v+1)*COORD_BITS +: COORD_BITS] < ymin)
            ymin = coordinates[(2*v+1)*COORD_BITS +: COORD_BITS];
      end
   end

   // Start address of row 0; arithmetic is naturally modulo 2^ADDR_BITS.
   assign base_addr = (layer_num ? ADDR_BITS'(LAYER_STRIDE) : '0)
                    + ADDR_BITS'(ymin) * ADDR_BITS'(ROW_STRIDE)
                    + ADDR_BITS'(xmin);

   assign edge_row = line_buffer[r_q*ROW_PIXELS +: ROW_PIXELS];

   span_mask_gen #(
      .ROW_PIXELS (ROW_PIXELS)
   ) u_span_mask_gen (
      .edge_row  (edge_row),
      .mode      (mode_q),
      .fill_mask (scan_mask),
      .empty     (scan_empty)
   );

   // Replacement value for every pixel position; the FILL step picks these
   // only where the mask is set.
   always_comb begin
      filled_row = '0;
      for (int p = 0; p < ROW_PIXELS; p++) begin
`ifdef FILL_BLEND_EN
         if (blend_q)
            filled_row[p*PIXEL_BITS +: PIXEL_BITS] = PIXEL_BITS'(blend_px(
               BLEND_MAX_BITS'(row_q[p*PIXEL_BITS +: PIXEL_BITS]),
               BLEND_MAX_BITS'(color_q)));
         else
            filled_row[p*PIXEL_BITS +: PIXEL_BITS] = color_q;
`else
         filled_row[p*PIXEL_BITS +: PIXEL_BITS] = color_q;
`endif
      end
   end

   // Next-state and datapath updates. The row address is kept in addr_q and
   // advanced by ROW_STRIDE per row, so it stays constant during each access.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      rc_d    = rc_q;
      mode_d  = mode_q;
      color_d = color_q;
      addr_d  = addr_q;
      row_d   = row_q;
      mask_d  = mask_q;
`ifdef FILL_BLEND_EN
      blend_d = blend_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start)
               state_d = ST_SETUP;
         end
         ST_SETUP: begin
            mode_d  = fill_mode;
            color_d = color_code;
`ifdef FILL_BLEND_EN
            blend_d = blend;
`endif
            rc_d    = (row_count > MAX_ROWS) ? MAX_ROWS : row_count;
            addr_d  = base_addr;
            r_d     = '0;
            state_d = (row_count == '0) ? ST_DONE : ST_RD_REQ;
         end
         ST_RD_REQ: begin
            if (mem_ack) begin
               row_d   = read_data;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            mask_d  = scan_mask;
            state_d = scan_empty ? ST_NEXT : ST_FILL;
         end
         ST_FILL: begin
            for (int p = 0; p < ROW_PIXELS; p++) begin
               if (mask_q[p])
                  row_d[p*PIXEL_BITS +: PIXEL_BITS] = filled_row[p*PIXEL_BITS +: PIXEL_BITS];
            end
            state_d = ST_WR_REQ;
         end
         ST_WR_REQ: begin
            if (mem_ack)
               state_d = ST_NEXT;
         end
         ST_NEXT: begin
            r_d     = r_q + RC_BITS'(1);
            addr_d  = addr_q + ADDR_BITS'(ROW_STRIDE);
            state_d = ((r_d == rc_q) || (r_d == MAX_ROWS)) ? ST_DONE : ST_RD_REQ;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         rc_q    <= '0;
         mode_q  <= '0;
         color_q <= '0;
         addr_q  <= '0;
         row_q   <= '0;
         mask_q  <= '0;
`ifdef FILL_BLEND_EN
         blend_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         rc_q    <= rc_d;
         mode_q  <= mode_d;
         color_q <= color_d;
         addr_q  <= addr_d;
         row_q   <= row_d;
         mask_q  <= mask_d;
`ifdef FILL_BLEND_EN
         blend_q <= blend_d;
`endif
      end
   end

   // Status and memory-port outputs decode directly from the state register.
   assign busy       = (state_q != ST_IDLE);
   assign fill_done  = (state_q == ST_DONE);
   assign mem_req    = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
   assign mem_we     = (state_q == ST_WR_REQ);
   assign address    = mem_req ? addr_q : '0;
   assign write_data = row_q;

endmodule
